// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed 2*DW / DW sequential restoring divider with saturation and divide-by-zero flag
module seq_divider #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            overflow
);

  localparam int              CW        = $clog2(2 * DW);
  localparam logic [CW-1:0]   LAST_STEP = CW'(2 * DW - 1);
  localparam logic [2*DW-1:0] POS_LIM   = (2*DW)'((2 ** (DW - 1)) - 1);
  localparam logic [2*DW-1:0] NEG_LIM   = (2*DW)'(2 ** (DW - 1));
  localparam logic [DW-1:0]   SAT_POS   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   SAT_NEG   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2*DW-1:0] q_sr;
  logic [DW-1:0]   rem_q;
  logic [DW-1:0]   dsr_mag;
  logic            dvd_neg;
  logic            dsr_neg;
  logic [CW-1:0]   step;

  logic [2*DW-1:0] dvd_abs;
  logic [DW-1:0]   dsr_abs;
  logic [DW:0]     shifted;
  logic [DW:0]     diff;
  logic            q_neg;
  logic            q_ovf;
  logic [DW-1:0]   q_low;
  logic [DW-1:0]   q_fix;
  logic [DW-1:0]   r_fix;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign dvd_abs = dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
  assign dsr_abs = divisor[DW-1] ? (~divisor + 1'b1) : divisor;

  // Partial remainder stays below |divisor| <= 2^(DW-1), so DW+1 bits hold the trial and its borrow.
  assign shifted = {rem_q, q_sr[2*DW-1]};
  assign diff    = shifted - {1'b0, dsr_mag};

  assign q_neg = dvd_neg ^ dsr_neg;
  assign q_ovf = q_neg ? (q_sr > NEG_LIM) : (q_sr > POS_LIM);
  assign q_low = q_sr[DW-1:0];
  assign q_fix = q_ovf ? (q_neg ? SAT_NEG : SAT_POS)
                       : (q_neg ? ({DW{1'b0}} - q_low) : q_low);
  assign r_fix = dvd_neg ? ({DW{1'b0}} - rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (step == LAST_STEP) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sr      <= '0;
      rem_q     <= '0;
      dsr_mag   <= '0;
      dvd_neg   <= 1'b0;
      dsr_neg   <= 1'b0;
      step      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
            end else begin
              q_sr    <= dvd_abs;
              rem_q   <= '0;
              dsr_mag <= dsr_abs;
              dvd_neg <= dividend[2*DW-1];
              dsr_neg <= divisor[DW-1];
              step    <= '0;
            end
          end
        end
        CALC: begin
          // Dividend bits shift out of the top while quotient bits shift in at the bottom.
          q_sr  <= {q_sr[2*DW-2:0], ~diff[DW]};
          rem_q <= diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
          step  <= step + 1'b1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= 1'b0;
          overflow  <= q_ovf;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic reference model
module tb_seq_divider;

  localparam int DW   = 8;
  localparam int QMAX = (2 ** (DW - 1)) - 1;
  localparam int QMIN = -(2 ** (DW - 1));

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_zero;
  logic            overflow;

  seq_divider #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: describes the DUT after the most recent rising edge.
  bit            m_live  = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_first = 1'b0;
  int            m_wait  = 0;
  int            m_cyc   = 0;
  logic [DW-1:0] cur_q   = '0;
  logic [DW-1:0] cur_r   = '0;
  logic          cur_dz  = 1'b0;
  logic          cur_ov  = 1'b0;
  logic [DW-1:0] pend_q, pend_r;
  logic          pend_dz, pend_ov;

  // Hand-computed expectations attached to a specific operation.
  int            lit_seq  = 0;
  int            lit_seen = 0;
  logic [DW-1:0] lit_q, lit_r;
  logic          lit_dz, lit_ov;
  int            lit_lat;

  function automatic void model(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] q, output logic [DW-1:0] r,
                                output logic dz, output logic ov);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; dz = 1'b1; ov = 1'b0;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      dz = 1'b0;
      ov = (iq > QMAX) || (iq < QMIN);
      if (ov) q = (iq > 0) ? DW'(QMAX) : DW'(QMIN);
      else    q = DW'(iq);
      r = DW'(ir);
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      if (m_busy || m_done) m_cyc++;
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("in_ready",  32'(in_ready),  32'(!m_busy && !m_done));
      chk("quotient",  32'(quotient),  32'(cur_q));
      chk("remainder", 32'(remainder), 32'(cur_r));
      chk("div_zero",  32'(div_zero),  32'(cur_dz));
      chk("overflow",  32'(overflow),  32'(cur_ov));
      if (m_done && m_first) begin
        m_first = 1'b0;
        if (lit_seq != lit_seen) begin
          lit_seen = lit_seq;
          chk("lit_quotient",  32'(quotient),  32'(lit_q));
          chk("lit_remainder", 32'(remainder), 32'(lit_r));
          chk("lit_div_zero",  32'(div_zero),  32'(lit_dz));
          chk("lit_overflow",  32'(overflow),  32'(lit_ov));
          chk("lit_latency",   32'(m_cyc),     32'(lit_lat));
        end
      end
    end
    // Predict the effect of the upcoming rising edge.
    if (!rst_n) begin
      m_live = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_first = 1'b0;
      cur_q = '0; cur_r = '0; cur_dz = 1'b0; cur_ov = 1'b0;
    end else if (m_live) begin
      if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_first = 1'b1;
          cur_q = pend_q; cur_r = pend_r; cur_dz = pend_dz; cur_ov = pend_ov;
        end
      end else if (in_valid) begin
        model(dividend, divisor, pend_q, pend_r, pend_dz, pend_ov);
        m_cyc = 0;
        if (pend_dz) begin
          m_done = 1'b1; m_first = 1'b1;
          cur_q = pend_q; cur_r = pend_r; cur_dz = pend_dz; cur_ov = pend_ov;
        end else begin
          m_busy = 1'b1;
          m_wait = 2 * DW + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lit(input logic [DW-1:0] q, input logic [DW-1:0] r,
                         input logic dz, input logic ov, input int lat);
    lit_q = q; lit_r = r; lit_dz = dz; lit_ov = ov; lit_lat = lat;
    lit_seq++;
  endtask

  // Issue one operation from an idle DUT; abort_at > 0 pulses reset in that cycle after accept.
  task automatic do_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                       input int hold, input int abort_at);
    int k;
    if (m_busy || m_done) begin
      $display("FAIL do_op: model not idle before issue");
      $fatal(1);
    end
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    tick();
    k = 1;
    while (m_busy && k < 64) begin
      rst_n    = (k != abort_at);
      in_valid = 1'($urandom);
      dividend = (2*DW)'($urandom);
      divisor  = DW'($urandom);
      tick();
      k++;
    end
    rst_n = 1'b1;
    if (m_busy) begin
      $display("FAIL do_op: operation did not complete in model");
      $fatal(1);
    end
    if (m_done) begin
      for (int h = 0; h < hold; h++) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        tick();
      end
      out_ready = 1'b1;
      in_valid  = 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2*DW-1:0] ca [6];
    logic [DW-1:0]   cb [6];
    logic [2*DW-1:0] a;
    logic [DW-1:0]   b;
    logic [DW-1:0]   qq;
    int              absb, rr, hold, abort_at;

    ca = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFF80};
    cb = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'h02};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tick();

    set_lit(8'hF8, 8'hFC, 1'b0, 1'b0, 18);
    do_op(16'hFFC4, 8'h07, 10, 0);
    set_lit(8'h7F, 8'h00, 1'b0, 1'b0, 18);
    do_op(16'h3F01, 8'h7F, 0, 0);
    set_lit(8'h80, 8'h00, 1'b0, 1'b0, 18);
    do_op(16'h4000, 8'h80, 2, 0);
    set_lit(8'h7F, 8'h00, 1'b0, 1'b1, 18);
    do_op(16'h8000, 8'hFF, 0, 0);
    set_lit(8'h00, 8'h00, 1'b1, 1'b0, 1);
    do_op(16'h1234, 8'h00, 3, 0);

    do_op(16'h7ABC, 8'h35, 0, 5);
    tick();

    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0: begin a = (2*DW)'($urandom); b = '0; end
        1, 2: begin a = (2*DW)'($urandom); b = DW'($urandom); end
        3: begin a = ca[$urandom % 6]; b = cb[$urandom % 6]; end
        default: begin
          b = DW'($urandom);
          if (b == '0) b = 8'h01;
          qq   = DW'($urandom);
          absb = (int'($signed(b)) < 0) ? -int'($signed(b)) : int'($signed(b));
          rr   = int'($urandom_range(0, absb - 1));
          if ($urandom % 2) rr = -rr;
          a = (2*DW)'(int'($signed(qq)) * int'($signed(b)) + rr);
        end
      endcase
      hold     = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
      abort_at = ($urandom % 50 == 0) ? int'($urandom_range(1, 17)) : 0;
      do_op(a, b, hold, abort_at);
      if ($urandom % 4 == 0) tick();
    end

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
